double_accumulate_seq: RTL and testbench

DOUBLE_ACCUMULATE_SEQ -- requirements
Module: double_accumulate_seq

---
 rtl/double_accumulate_seq.sv | 178 +++++++++++++++++
 tb/tb_double_accumulate_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/double_accumulate_seq.sv
// double_accumulate_seq
// Streams a vector of IEEE-754 doubles through an external double adder and
// returns the running sum together with the number of elements summed.
// The sum starts at +0.0 for every vector. Every element goes through the
// adder, including the only element of a one-element vector.
//
// Optional build macro DACC_SUBTRACT_EN adds the input in_sub. When in_sub is
// 1, the element is subtracted (acc - x) by flipping its sign bit before it is
// sent to the adder.
//
// All handshake outputs are registered. A strobe or ack rises on the cycle
// after its state is entered and falls on the edge that completes the
// transfer. Because only the current state can raise its own flag, at most
// one of them is high in any cycle.
// The adder shares the reset of this block, so any partial sum it holds is
// discarded together with ours.

module double_accumulate_seq #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,

    input  logic [63:0]        in_data,
    input  logic               in_stb,
    input  logic               in_last,
`ifdef DACC_SUBTRACT_EN
    input  logic               in_sub,
`endif
    output logic               in_ack,

    output logic [63:0]        add_a,
    output logic               add_a_stb,
    input  logic               add_a_ack,
    output logic [63:0]        add_b,
    output logic               add_b_stb,
    input  logic               add_b_ack,

    input  logic [63:0]        add_z,
    input  logic               add_z_stb,
    output logic               add_z_ack,

    output logic [63:0]        out_z,
    output logic               out_z_stb,
    input  logic               out_z_ack,
    output logic [COUNT_W-1:0] out_count
);

    typedef enum logic [2:0] {
        IDLE,
        SEND_A,
        SEND_B,
        WAIT_Z,
        PUT_Z
    } state_t;

    state_t             state_q;
    logic [63:0]        acc_q;
    logic [63:0]        elem_q;
    logic               last_q;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;
    logic               in_ack_q;
    logic               add_a_stb_q;
    logic               add_b_stb_q;
    logic               add_z_ack_q;
    logic               out_z_stb_q;
    logic [63:0]        operand_d;

    // The element count saturates at all-ones. Summation keeps going past
    // that point; only the count stops.
    always_comb begin
        count_d = count_q;
        if (count_q != {COUNT_W{1'b1}}) begin
            count_d = count_q + 1'b1;
        end
    end

    // Builds the value stored as the adder's B operand. In subtract builds the
    // sign bit is flipped at capture time, so add_b comes straight from a
    // register.
    always_comb begin
`ifdef DACC_SUBTRACT_EN
        operand_d = {in_data[63] ^ in_sub, in_data[62:0]};
`else
        operand_d = in_data;
`endif
    end

    // Main sequencer: one state per handshake. Each handshake flag is raised
    // on the first cycle in its state and lowered on the edge where the
    // transfer completes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            acc_q       <= 64'h0;
            elem_q      <= 64'h0;
            last_q      <= 1'b0;
            count_q     <= '0;
            in_ack_q    <= 1'b0;
            add_a_stb_q <= 1'b0;
            add_b_stb_q <= 1'b0;
            add_z_ack_q <= 1'b0;
            out_z_stb_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!in_ack_q) begin
                        in_ack_q <= 1'b1;
                    end else if (in_stb) begin
                        elem_q   <= operand_d;
                        last_q   <= in_last;
                        count_q  <= count_d;
                        in_ack_q <= 1'b0;
                        state_q  <= SEND_A;
                    end
                end

                SEND_A: begin
                    if (!add_a_stb_q) begin
                        add_a_stb_q <= 1'b1;
                    end else if (add_a_ack) begin
                        add_a_stb_q <= 1'b0;
                        state_q     <= SEND_B;
                    end
                end

                SEND_B: begin
                    if (!add_b_stb_q) begin
                        add_b_stb_q <= 1'b1;
                    end else if (add_b_ack) begin
                        add_b_stb_q <= 1'b0;
                        state_q     <= WAIT_Z;
                    end
                end

                WAIT_Z: begin
                    if (!add_z_ack_q) begin
                        add_z_ack_q <= 1'b1;
                    end else if (add_z_stb) begin
                        acc_q       <= add_z;
                        add_z_ack_q <= 1'b0;
                        state_q     <= last_q ? PUT_Z : IDLE;
                    end
                end

                PUT_Z: begin
                    if (!out_z_stb_q) begin
                        out_z_stb_q <= 1'b1;
                    end else if (out_z_ack) begin
                        out_z_stb_q <= 1'b0;
                        acc_q       <= 64'h0;
                        count_q     <= '0;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Outputs come straight from registers. acc_q and count_q do not change
    // while out_z_stb is high, so out_z and out_count stay stable during a
    // stalled output.
    assign in_ack    = in_ack_q;
    assign add_a     = acc_q;
    assign add_a_stb = add_a_stb_q;
    assign add_b     = elem_q;
    assign add_b_stb = add_b_stb_q;
    assign add_z_ack = add_z_ack_q;
    assign out_z     = acc_q;
    assign out_z_stb = out_z_stb_q;
    assign out_count = count_q;

endmodule

// File: tb/tb_double_accumulate_seq.sv
// Testbench for double_accumulate_seq.
// A behavioural double adder built on real arithmetic serves the adder
// channels. The block is built with a 3-bit count so that count saturation
// can be reached quickly.

module tb_double_accumulate_seq;

   localparam int CW = 3;

   logic          clk;
   logic          rst;
   logic [63:0]   inData;
   logic          inStb;
   logic          inLast;
   logic          inSub;
   logic          inAck;
   logic [63:0]   addA;
   logic          addAStb;
   logic          addAAck;
   logic [63:0]   addB;
   logic          addBStb;
   logic          addBAck;
   logic [63:0]   addZ;
   logic          addZStb;
   logic          addZAck;
   logic [63:0]   outZ;
   logic          outZStb;
   logic          outZAck;
   logic [CW-1:0] outCount;

   int errors = 0;
   int checks = 0;
   int exclViolations = 0;

   typedef struct {
      logic [63:0] data;
      bit          last;
      bit          sub;
      logic [63:0] expZ;
      int          expCount;
   } vec_t;

   vec_t vecs[$];

   double_accumulate_seq #(.COUNT_W(CW)) dut (
      .clk(clk),
      .rst(rst),
      .in_data(inData),
      .in_stb(inStb),
      .in_last(inLast),
`ifdef DACC_SUBTRACT_EN
      .in_sub(inSub),
`endif
      .in_ack(inAck),
      .add_a(addA),
      .add_a_stb(addAStb),
      .add_a_ack(addAAck),
      .add_b(addB),
      .add_b_stb(addBStb),
      .add_b_ack(addBAck),
      .add_z(addZ),
      .add_z_stb(addZStb),
      .add_z_ack(addZAck),
      .out_z(outZ),
      .out_z_stb(outZStb),
      .out_z_ack(outZAck),
      .out_count(outCount)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Stops a run that has hung
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Behavioural adder. The acks are held high. A channel is sampled at the
   // falling edge before the rising edge that transfers it. The result is
   // presented a few cycles after B arrives. The adder is cleared whenever
   // reset is seen low.
   initial begin : adderModel
      logic [63:0] aReg;
      logic [63:0] bReg;
      int          delay;
      bit          zPending;
      aReg = 64'h0;
      bReg = 64'h0;
      delay = 0;
      zPending = 0;
      addAAck = 1'b1;
      addBAck = 1'b1;
      addZStb = 1'b0;
      addZ = 64'h0;
      forever begin
         @(negedge clk);
         if (zPending) begin
            addZStb = 1'b0;
            zPending = 0;
         end
         if (!rst) begin
            addZStb = 1'b0;
            delay = 0;
            zPending = 0;
         end else begin
            if (addAStb) aReg = addA;
            if (addBStb) begin
               bReg = addB;
               delay = 4;
            end
            if (delay > 0) begin
               delay--;
               if (delay == 0) begin
                  addZ = $realtobits($bitstoreal(aReg) + $bitstoreal(bReg));
                  addZStb = 1'b1;
               end
            end
            if (addZStb && addZAck) zPending = 1;
         end
      end
   end

   // Counts cycles in which more than one handshake flag is high
   always @(negedge clk) begin
      if ($countones({inAck, addAStb, addBStb, addZAck, outZStb}) > 1) exclViolations++;
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Offers one element and returns on the falling edge after it is taken
   task automatic applyStimulus(input logic [63:0] data, input bit last, input bit sub);
      int n;
      inData = data;
      inLast = last;
      inSub = sub;
      inStb = 1'b1;
      n = 0;
      while (!inAck && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!inAck) checkOutput("in_ack_timeout", 64'(inAck), 64'h1);
      @(negedge clk);
      inStb = 1'b0;
   endtask

   // Waits, with a bound, for out_z_stb and then checks the result
   task automatic getResult(input string name, input logic [63:0] expZ, input int expCount);
      int n;
      n = 0;
      while (!outZStb && n < 300) begin
         @(negedge clk);
         n++;
      end
      checkOutput({name, "_stb"}, 64'(outZStb), 64'h1);
      checkOutput({name, "_z"}, outZ, expZ);
      checkOutput({name, "_count"}, 64'(outCount), 64'(expCount));
      @(negedge clk);
   endtask

   // Directed test sequence
   initial begin
      int n;
      rst = 1'b0;
      inData = 64'h0;
      inStb = 1'b0;
      inLast = 1'b0;
      inSub = 1'b0;
      outZAck = 1'b1;

      // Checks the state held during reset, then releases reset
      repeat (3) @(negedge clk);
      checkOutput("reset_flags", 64'({inAck, addAStb, addBStb, addZAck, outZStb}), 64'h0);
      checkOutput("reset_count", 64'(outCount), 64'h0);
      #1 rst = 1'b1;

      // Vector table: expZ and expCount apply only to an entry with last set
      vecs.push_back('{64'h3FF0000000000000, 1'b0, 1'b0, 64'h0, 0});
      vecs.push_back('{64'h4000000000000000, 1'b0, 1'b0, 64'h0, 0});
      vecs.push_back('{64'h4008000000000000, 1'b1, 1'b0, 64'h4018000000000000, 3});
      vecs.push_back('{64'h4004000000000000, 1'b1, 1'b0, 64'h4004000000000000, 1});
      vecs.push_back('{64'h7FF0000000000000, 1'b0, 1'b0, 64'h0, 0});
      vecs.push_back('{64'h3FF0000000000000, 1'b1, 1'b0, 64'h7FF0000000000000, 2});
      vecs.push_back('{64'h3FE0000000000000, 1'b0, 1'b0, 64'h0, 0});
      vecs.push_back('{64'h3FD0000000000000, 1'b1, 1'b0, 64'h3FE8000000000000, 2});
      vecs.push_back('{64'hBFF0000000000000, 1'b0, 1'b0, 64'h0, 0});
      vecs.push_back('{64'h3FF0000000000000, 1'b1, 1'b0, 64'h0000000000000000, 2});
      for (int i = 0; i < 8; i++) vecs.push_back('{64'h3FF0000000000000, 1'b0, 1'b0, 64'h0, 0});
      vecs.push_back('{64'h3FF0000000000000, 1'b1, 1'b0, 64'h4022000000000000, 7});
`ifdef DACC_SUBTRACT_EN
      vecs.push_back('{64'h4014000000000000, 1'b0, 1'b0, 64'h0, 0});
      vecs.push_back('{64'h4008000000000000, 1'b1, 1'b1, 64'h4000000000000000, 2});
`endif

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].data, vecs[i].last, vecs[i].sub);
         if (vecs[i].last) getResult($sformatf("vec%0d", i), vecs[i].expZ, vecs[i].expCount);
      end

      // Output stall: out_z_ack is held low for ten cycles
      outZAck = 1'b0;
      applyStimulus(64'h4000000000000000, 1'b1, 1'b0);
      n = 0;
      while (!outZStb && n < 300) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 10; i++) begin
         checkOutput("stall_stb", 64'(outZStb), 64'h1);
         checkOutput("stall_z", outZ, 64'h4000000000000000);
         checkOutput("stall_count", 64'(outCount), 64'h1);
         checkOutput("stall_in_ack", 64'(inAck), 64'h0);
         @(negedge clk);
      end
      outZAck = 1'b1;
      @(negedge clk);
      checkOutput("stall_release", 64'(outZStb), 64'h0);
      applyStimulus(64'h4004000000000000, 1'b1, 1'b0);
      getResult("after_stall", 64'h4004000000000000, 1);

      // Reset while waiting for the adder result
      applyStimulus(64'h4000000000000000, 1'b0, 1'b0);
      n = 0;
      while (!addZAck && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("reach_wait_z", 64'(addZAck), 64'h1);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("midreset_flags", 64'({inAck, addAStb, addBStb, addZAck, outZStb}), 64'h0);
      checkOutput("midreset_count", 64'(outCount), 64'h0);
      #1 rst = 1'b1;
      @(negedge clk);
      checkOutput("midreset_idle", 64'(inAck), 64'h1);
      applyStimulus(64'h3FF0000000000000, 1'b1, 1'b0);
      getResult("after_reset", 64'h3FF0000000000000, 1);

      checkOutput("exclusive_flags", 64'(exclViolations), 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
